// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int unsigned SYNC_STAGES     = 2;
    localparam int unsigned DEF_CLK_FREQ    = 100_000_000;
    localparam int unsigned DEF_GATE_CYCLES = DEF_CLK_FREQ;
    localparam int unsigned GATE_W          = 32;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input plus a rising-edge pulse.
module sync_edge_det
    import freq_meter_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse_c
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign pulse_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a GATE_CYCLES clk window and presents the count.
// Define FREQ_METER_CONTINUOUS_EN for free-running back-to-back windows with a 1-cycle valid pulse.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = DEF_CLK_FREQ,
    parameter int unsigned GATE_CYCLES = CLK_FREQ,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    input  logic             freq_ready,
    output logic             overflow
);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t             state_q, state_d;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic [CNT_W-1:0]   edge_q, edge_d, freq_d, edge_sum_c;
    logic               sat_q, sat_d, sat_sum_c;
    logic               valid_d, ovf_d, busy_d;
    logic               pulse_c;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .din     (sig_in),
        .pulse_c (pulse_c)
    );

`ifdef FREQ_METER_CONTINUOUS_EN
    logic unused_c;
    assign unused_c = start ^ freq_ready;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state, counters and result; a pulse in the closing cycle is included
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        edge_d  = edge_q;
        sat_d   = sat_q;
        freq_d  = freq_out;
        ovf_d   = overflow;
        valid_d = freq_valid;

        sat_sum_c  = sat_q | (pulse_c & (edge_q == CNT_MAX));
        edge_sum_c = (pulse_c && (edge_q != CNT_MAX)) ? edge_q + CNT_W'(1) : edge_q;

        case (state_q)
            ST_IDLE: begin
`ifdef FREQ_METER_CONTINUOUS_EN
                state_d = ST_GATE;
                gate_d  = '0;
                edge_d  = '0;
                sat_d   = 1'b0;
`else
                if (start) begin
                    state_d = ST_GATE;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end
`endif
            end
            ST_GATE: begin
                if (gate_q == GATE_LAST) begin
                    freq_d  = edge_sum_c;
                    ovf_d   = sat_sum_c;
                    valid_d = 1'b1;
`ifdef FREQ_METER_CONTINUOUS_EN
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
`else
                    state_d = ST_HOLD;
`endif
                end else begin
                    gate_d  = gate_q + GATE_W'(1);
                    edge_d  = edge_sum_c;
                    sat_d   = sat_sum_c;
`ifdef FREQ_METER_CONTINUOUS_EN
                    valid_d = 1'b0;
`endif
                end
            end
            ST_HOLD: begin
                if (freq_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gate_q     <= '0;
            edge_q     <= '0;
            sat_q      <= 1'b0;
            freq_out   <= '0;
            overflow   <= 1'b0;
            freq_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            gate_q     <= gate_d;
            edge_q     <= edge_d;
            sat_q      <= sat_d;
            freq_out   <= freq_d;
            overflow   <= ovf_d;
            freq_valid <= valid_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: a 32-bit and a saturating 4-bit instance share all inputs.
module tb_freq_meter;

    localparam int unsigned G    = 1000;
    localparam int unsigned HIST = 65536;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sig_in = 1'b0;
    logic        start = 1'b0;
    logic        freq_ready = 1'b0;
    logic        busy, freq_valid, overflow;
    logic [31:0] freq_out;
    logic        busy4, freq_valid4, overflow4;
    logic [3:0]  freq_out4;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .busy(busy),
        .freq_out(freq_out), .freq_valid(freq_valid), .freq_ready(freq_ready),
        .overflow(overflow)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .busy(busy4),
        .freq_out(freq_out4), .freq_valid(freq_valid4), .freq_ready(freq_ready),
        .overflow(overflow4)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sampled sig_in value at every rising clk edge, indexed by edge number
    int unsigned cyc = 0;
    bit          hist [HIST];
    always @(posedge clk) begin
        if (cyc < HIST) hist[cyc] = sig_in;
        cyc = cyc + 1;
    end

    // Waveform generator: 0 = constant level, 1 = periodic, 2 = random runs of 2..9 cycles
    int unsigned sig_mode = 0, per = 10, hi = 5, ph = 0, run = 0;
    bit          lvl = 1'b0;
    always @(negedge clk) begin
        case (sig_mode)
            0: sig_in = lvl;
            1: begin
                sig_in = (ph < hi);
                ph = (ph + 1 >= per) ? 0 : ph + 1;
            end
            default: begin
                if (run == 0) begin
                    sig_in = ~sig_in;
                    run = $urandom_range(2, 9);
                end
                run--;
            end
        endcase
    end

    // Edge sampled at edge k reflects a 0->1 transition seen 3 and 2 edges earlier
    function automatic int unsigned count_edges(input int unsigned first, input int unsigned last);
        int unsigned n = 0;
        for (int unsigned k = first; k <= last; k++)
            if (k >= 3 && k < HIST && hist[k-2] && !hist[k-3]) n++;
        return n;
    endfunction

    task automatic wait_valid(output int unsigned tv, output bit ok);
        ok = 1'b0;
        tv = 0;
        for (int i = 0; i < int'(G) + 20; i++) begin
            @(posedge clk);
            #1;
            if (freq_valid) begin
                tv = cyc - 1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("valid_timeout", 0, 1);
    endtask

    task automatic measure(input string tag, input int unsigned hold, output int unsigned got);
        int unsigned t0, tv, exp;
        bit ok;
        got = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc - 1;
        start = 1'b0;
        wait_valid(tv, ok);
        if (ok) begin
            exp = count_edges(t0 + 1, t0 + G);
            got = freq_out;
            check({tag, "_lat"}, tv - t0, G);
            check({tag, "_cnt"}, freq_out, exp);
            check({tag, "_ovf"}, overflow, 0);
            check({tag, "_valid4"}, freq_valid4, 1);
            check({tag, "_cnt4"}, freq_out4, (exp > 15) ? 15 : exp);
            check({tag, "_ovf4"}, overflow4, (exp > 15) ? 1 : 0);
            check({tag, "_busy"}, busy, 1);
            if (hold > 0) begin
                repeat (hold / 2) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (hold - hold / 2) @(negedge clk);
                check({tag, "_hold_cnt"}, freq_out, exp);
                check({tag, "_hold_valid"}, freq_valid, 1);
                check({tag, "_hold_busy"}, busy, 1);
            end
            @(negedge clk);
            freq_ready = 1'b1;
            @(posedge clk);
            #1;
            check({tag, "_ack_valid"}, freq_valid, 0);
            check({tag, "_ack_busy"}, busy, 0);
            check({tag, "_ack_valid4"}, freq_valid4, 0);
            @(negedge clk);
            freq_ready = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check({tag, "_noqueue"}, busy, 0);
        end
    endtask

    initial begin
        int unsigned got;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_freq", freq_out, 0);
        check("rst_valid", freq_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy4", busy4, 0);
        check("rst_freq4", freq_out4, 0);
        check("rst_valid4", freq_valid4, 0);
        check("rst_ovf4", overflow4, 0);

`ifdef FREQ_METER_CONTINUOUS_EN
        begin
            int unsigned tv, prev;
            bit ok;
            prev = 0;
            @(negedge clk);
            rst = 1'b1;
            ph = 0; per = 10; hi = 5; sig_mode = 1;
            start = 1'b1;
            for (int w = 0; w < 4; w++) begin
                wait_valid(tv, ok);
                if (!ok) break;
                check("cont_cnt", freq_out, count_edges(tv - G + 1, tv));
                check("cont_cnt100", freq_out, 100);
                check("cont_ovf", overflow, 0);
                if (w > 0) check("cont_period", tv - prev, G);
                prev = tv;
                @(posedge clk);
                #1;
                check("cont_pulse", freq_valid, 0);
                check("cont_busy", busy, 1);
            end
            start = 1'b0;
        end
`else
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        ph = 0; per = 10; hi = 5; sig_mode = 1;
        measure("p10", 50, got);
        check("p10_exact", got, 100);

        lvl = 1'b0; sig_mode = 0;
        repeat (10) @(negedge clk);
        measure("zero", 0, got);
        check("zero_exact", got, 0);

        ph = 0; per = 4; hi = 2; sig_mode = 1;
        measure("p4", 3, got);
        check("p4_exact", got, 250);
        check("p4_sat4", freq_out4, 15);
        check("p4_ovf4", overflow4, 1);

        for (int i = 0; i < 6; i++) begin
            per = $urandom_range(4, 30);
            hi = $urandom_range(2, per - 2);
            ph = 0;
            sig_mode = $urandom_range(1, 2);
            measure("rand", $urandom_range(0, 20), got);
        end

        // Abort mid-gate with asynchronous reset
        ph = 0; per = 10; hi = 5; sig_mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (500) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", freq_valid, 0);
        check("abort_freq", freq_out, 0);
        check("abort_ovf", overflow, 0);
        check("abort_freq4", freq_out4, 0);
        check("abort_ovf4", overflow4, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_idle_valid", freq_valid, 0);
        measure("after_rst", 0, got);
        check("after_rst_exact", got, 100);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of an external slow signal against the 100 MHz system clock. It is the measuring counterpart of the on-chip clock divider.
- Opens a gate window of GATE_CYCLES clk cycles (default 1 s) and counts rising edges of sig_in inside that window. It then presents the count with a valid/ready handshake.
- Sits beside the divider on the board top. Used to self-check divided clocks or to read external test signals.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz; informational, used only to derive the GATE_CYCLES default.
- GATE_CYCLES, 100_000_000: gate window length in clk cycles; legal range 2..2^32-1.
- CNT_W, 32: width of the edge counter and of freq_out.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- sig_in  in  1  asynchronous signal to be measured.
- start  in  1  one-shot measurement request; sampled only in IDLE.
- busy  out  1  high in GATE and HOLD.
- freq_out  out  CNT_W  edge count of the last completed window; Hz when GATE_CYCLES = CLK_FREQ.
- freq_valid  out  1  result available.
- freq_ready  in  1  consumer accepts the result.
- overflow  out  1  the edge count saturated during the last window.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state = IDLE; busy = 0; freq_out = 0; freq_valid = 0; overflow = 0.
  - Gate counter = 0, edge counter = 0, synchronizer flops = 0.
- Input path: sig_in passes through a 2-flop synchronizer plus one delay flop. A rising edge is sync_q=1 and prev_q=0, giving 3 clk latency from pin to edge pulse. Edges shorter than 2 clk high or low are not guaranteed to be counted.
- States:
  - IDLE: if start=1 at edge T0, go to GATE and clear both counters.
  - GATE: the gate counter increments every clk. The edge counter increments on each edge pulse. When the gate counter reaches GATE_CYCLES-1:
    - freq_out is loaded with the count including an edge pulse in that same cycle.
    - overflow is loaded with the saturation flag.
    - freq_valid goes to 1 and the state moves to HOLD.
    - The first freq_valid=1 appears at edge T0+GATE_CYCLES, so exactly GATE_CYCLES edge-sampling cycles are counted.
  - HOLD: freq_out, overflow and freq_valid stay stable. When freq_valid and freq_ready are both 1 at an edge, freq_valid goes to 0 and the state returns to IDLE.
- start while busy is ignored: no queueing, no restart.
- Saturation: the edge counter stops at 2^CNT_W-1 and never wraps; the internal saturation flag is set.
- freq_ready is ignored outside HOLD.
- A new measurement can start at the first edge back in IDLE, i.e. one cycle after the handshake.
- Reset asserted mid-GATE or mid-HOLD aborts immediately. The partial count is discarded and no freq_valid is produced.

Optional Feature:
- Macro: FREQ_METER_CONTINUOUS_EN.
- Defined:
  - The block leaves IDLE on the first clk after reset release and runs gates back-to-back; start is ignored.
  - On each window close, freq_out/overflow are updated and freq_valid is a 1-cycle pulse; freq_ready is ignored.
  - The next window starts in the same cycle, with no gap cycle.
  - An edge pulse in the closing cycle belongs to the closing window.
  - busy stays 1 after leaving IDLE.
- Undefined: single-shot start/handshake behaviour as above.

Decomposition:
- Package freq_meter_pkg:
  - State encoding for IDLE/GATE/HOLD, 2 bits.
  - SYNC_STAGES = 2.
  - Default gate constant.
- Sub-module sync_edge_det: synchronizer plus rising-edge pulse; reusable for other async inputs.

Test Plan (GATE_CYCLES=1000, CNT_W=32 unless noted):
- sig_in period 10 clk, start pulse -> freq_valid at start+1000 clk, freq_out=100, overflow=0.
- sig_in held 0, start -> freq_out=0, freq_valid after 1000 clk.
- CNT_W=4, sig_in period 4 clk -> freq_out=15, overflow=1.
- freq_ready low 50 cycles after valid, start pulsed during HOLD -> freq_out stable, valid held, no restart; freq_ready=1 -> IDLE next clk.
- rst low at gate cycle 500 -> all outputs 0 at once; fresh start gives full result 100.
- FREQ_METER_CONTINUOUS_EN, period 10 -> valid pulses every 1000 clk, each freq_out=100.
